// File: rtl/voxel_scan_ctrl.sv
// Double-buffered 8x8x8 RGB voxel frame store with a one-voxel-at-a-time scanner
// feeding the LED cube display driver; buffer swaps happen only between frames.
module voxel_scan_ctrl #(
  parameter int DWELL = 64,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       wr_en,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic [2:0] wr_z,
  input  logic [2:0] wr_color,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_done,
  output logic [3:0] oX,
  output logic [3:0] oY,
  output logic [3:0] oZ,
  output logic [3:0] color,
  output logic       enable
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DW_PRE  = CNT_W'(DWELL - 2);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] DW_ONE  = CNT_W'(1);

  logic [2:0] mem0 [512];
  logic [2:0] mem1 [512];
  logic [2:0] rd0_q, rd1_q;

  state_t           state_q, state_d;
  logic [8:0]       addr_q, addr_d;
  logic [8:0]       cur_q, cur_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             front_q, front_d;
  logic             valid_q, valid_d;
  logic [2:0]       color_q, color_d;
  logic             en_q, en_d;
  logic             swap_ack_q, swap_ack_d;
  logic             frame_done_q, frame_done_d;
  logic             rd_en_s;

  // Both buffers are read together so the front choice can be made after a frame-end swap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_q) mem0[{wr_z, wr_y, wr_x}] <= wr_color;
      else         mem1[{wr_z, wr_y, wr_x}] <= wr_color;
    end
    if (rd_en_s) begin
      rd0_q <= mem0[addr_q];
      rd1_q <= mem1[addr_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cur_d        = cur_q;
    dwell_d      = dwell_q;
    front_d      = front_q;
    valid_d      = valid_q;
    color_d      = color_q;
    en_d         = en_q;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    rd_en_s      = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d  = 9'd0;
        valid_d = 1'b0;
        en_d    = 1'b0;
        if (swap_req) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
        end else begin
          front_d = front_q;
        end
        if (run) begin
          state_d = SCAN;
          dwell_d = DW_PRE;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!run) begin
          state_d = IDLE;
          en_d    = 1'b0;
          addr_d  = 9'd0;
          valid_d = 1'b0;
        end else if (dwell_q == DW_PRE) begin
          // Prefetch the next voxel and blank for the last cycle of this slot.
          rd_en_s = 1'b1;
          addr_d  = addr_q + 9'd1;
          dwell_d = dwell_q + DW_ONE;
          en_d    = 1'b0;
        end else if (dwell_q == DW_LAST) begin
          dwell_d = {CNT_W{1'b0}};
          valid_d = 1'b1;
          if (valid_q && (cur_q == 9'd511)) begin
            frame_done_d = 1'b1;
            if (swap_req) begin
              front_d    = ~front_q;
              swap_ack_d = 1'b1;
            end else begin
              front_d = front_q;
            end
          end else begin
            front_d = front_q;
          end
          cur_d   = valid_q ? (cur_q + 9'd1) : 9'd0;
          color_d = front_d ? rd1_q : rd0_q;
          en_d    = (color_d != 3'd0);
        end else begin
          dwell_d = dwell_q + DW_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= 9'd0;
      cur_q        <= 9'd0;
      dwell_q      <= {CNT_W{1'b0}};
      front_q      <= 1'b0;
      valid_q      <= 1'b0;
      color_q      <= 3'd0;
      en_q         <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cur_q        <= cur_d;
      dwell_q      <= dwell_d;
      front_q      <= front_d;
      valid_q      <= valid_d;
      color_q      <= color_d;
      en_q         <= en_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oX         = {1'b0, cur_q[2:0]};
  assign oY         = {1'b0, cur_q[5:3]};
  assign oZ         = {1'b0, cur_q[8:6]};
  assign color      = {1'b0, color_q};
  assign enable     = en_q;
  assign swap_ack   = swap_ack_q;
  assign frame_done = frame_done_q;

endmodule
